prio_encoder_rr_pipe: RTL and testbench
=======================================

// Module: prio_encoder_rr_pipe
// PURPOSE
//  Parametrised, registered priority encoder with a valid/ready handshake on both sides.
//  Accepts a WIDTH-bit request vector and returns the index of the winning bit one cycle later.
//  Two runtime modes: fixed (highest set bit wins) and round-robin (rotating downward priority).
//  Sits between request-collection logic and any index consumer (mux select, arbiter grant, IRQ id).
// PARAMETERS
//  WIDTH   16  request vector width, >= 2
//  IDX_W   4   index width, must equal $clog2(WIDTH); elaboration error otherwise
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      req/rr_mode are valid this cycle
//  in_ready   out  1      block can accept; in_ready = !out_valid || out_ready
//  req        in   WIDTH  request vector, bit i = request from source i
//  rr_mode    in   1      0 = fixed priority, 1 = round-robin; sampled with req
//  out_valid  out  1      out_idx/out_none hold a result
//  out_ready  in   1      consumer takes result this cycle
//  out_idx    out  IDX_W  winning index
//  out_none   out  1      1 = accepted req was all zeros (out_idx forced to 0)
// BEHAVIOUR
//  - Reset (rst_n low, async): out_valid=0, out_idx=0, out_none=0, last_grant=0.
//  - Accept = in_valid && in_ready. Result appears on out_* the cycle after accept (latency 1).
//  - out_valid set on accept; cleared when out_valid && out_ready && !accept.
//    Accept + drain in the same cycle: out_valid stays 1, new result loads (full throughput).
//  - Stall: while out_valid && !out_ready, in_ready=0 and out_idx/out_none hold stable.
//  - Fixed mode: out_idx = highest i with req[i]=1 (bit WIDTH-1 highest priority).
//  - RR mode: candidates with i < last_grant take precedence; winner = highest such i.
//    If none exists, winner = highest set bit overall (wrap-around to top).
//  - last_grant (IDX_W reg) loads the winner on every accept with req != 0, in either mode.
//    Holds on req == 0 and on no-accept.
//  - last_grant=0 after reset, so the first RR grant equals the fixed-mode result.
//  - req == 0: out_none=1, out_idx=0, last_grant unchanged.
//  - Mode may change on any accept; the new mode applies to that same request.
//    last_grant is never cleared by a mode change.
//  - Reset mid-stall discards the pending result; there is no partial output.
//  - Only one result is buffered; there is no skid buffer.
// CONFIGURATION
//  PRIENC_ONEHOT_EN defined: adds port out_onehot (out, WIDTH) = 1 << out_idx, registered with out_idx.
//    It is all zeros when out_none=1 and on reset, and is held stable during a stall.
//  PRIENC_ONEHOT_EN undefined: out_onehot port and its register are absent; all other behaviour is identical.
// TESTING
//  1. Reset, fixed mode, req=16'h8001 -> next cycle out_valid=1, out_idx=15, out_none=0.
//  2. Fixed mode, req=16'h0000 -> out_none=1, out_idx=0; then req=16'h0004 -> out_idx=2, out_none=0.
//  3. RR mode, req=16'h8421 held for 5 accepts, out_ready=1 -> out_idx sequence 15,10,5,0,15.
//  4. Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, out_idx stable;
//     raise out_ready with a new in_valid -> back-to-back results with no bubble.
//  5. RR grant 10, then fixed req=16'h0C00 -> 11; then RR req=16'h0C00 -> 10 (last_grant=11).
//  6. Assert rst_n=0 asynchronously mid-stall -> out_valid, out_idx and out_onehot (if enabled) clear immediately;
//     run with and without PRIENC_ONEHOT_EN and check out_onehot = 1<<out_idx.

Source files
------------

// File: rtl/prio_encoder_rr_pipe.sv
// Registered priority encoder (fixed / round-robin) with valid/ready on both sides.
// Optional one-hot grant output when PRIENC_ONEHOT_EN is defined.
module prio_encoder_rr_pipe #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] req,
  input  logic             rr_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none
`ifdef PRIENC_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] out_onehot
`endif
);

  if (WIDTH < 2) begin : g_bad_width
    $error("prio_encoder_rr_pipe: WIDTH must be >= 2");
  end
  if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
    $error("prio_encoder_rr_pipe: IDX_W must equal $clog2(WIDTH)");
  end

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] fix_idx;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_hit;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             accept;

  assign any_req  = |req;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Ascending scan: the last hit is the highest set bit, both overall and below last_grant.
  always_comb begin
    fix_idx = '0;
    rr_idx  = '0;
    rr_hit  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        fix_idx = IDX_W'(i);
        if (i < int'(last_grant)) begin
          rr_idx = IDX_W'(i);
          rr_hit = 1'b1;
        end
      end
    end
    win_idx = (rr_mode && rr_hit) ? rr_idx : fix_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_none   <= 1'b0;
      last_grant <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= any_req ? win_idx : '0;
      out_none  <= !any_req;
      if (any_req) begin
        last_grant <= win_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PRIENC_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
    end else if (accept) begin
      out_onehot <= any_req ? ({{(WIDTH-1){1'b0}}, 1'b1} << win_idx) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_prio_encoder_rr_pipe.sv
// Scoreboard bench for prio_encoder_rr_pipe: directed scenarios plus randomized traffic
// checked against a search-based reference model.
module tb_prio_encoder_rr_pipe;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] req;
  logic             rr_mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_none;
`ifdef PRIENC_ONEHOT_EN
  logic [WIDTH-1:0] out_onehot;
`endif

  prio_encoder_rr_pipe #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .req(req),
    .rr_mode(rr_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_none(out_none)
`ifdef PRIENC_ONEHOT_EN
    ,
    .out_onehot(out_onehot)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit none;
  } exp_t;

  exp_t exp_q[$];
  int   seen_q[$];
  int   model_lg;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: search downward from just below the last grant, then from the top.
  function automatic exp_t model(input logic [WIDTH-1:0] r, input logic rr);
    exp_t e;
    int start;
    e.idx  = 0;
    e.none = 1'b1;
    if (r == '0) return e;
    e.none = 1'b0;
    start = rr ? model_lg - 1 : -1;
    for (int i = start; i >= 0; i--) begin
      if (r[i]) begin
        e.idx = i;
        model_lg = i;
        return e;
      end
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r[i]) begin
        e.idx = i;
        break;
      end
    end
    model_lg = e.idx;
    return e;
  endfunction

  // Issuer: inputs are stable mid-cycle, so this predicts the accept at the next edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(req, rr_mode));
  end

  // Monitor: whatever the DUT shows must be the oldest outstanding prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || out_ready));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
        chk("out_none", 32'(out_none), 32'(exp_q[0].none));
`ifdef PRIENC_ONEHOT_EN
        chk("out_onehot", 32'(out_onehot), exp_q[0].none ? 32'd0 : (32'd1 << exp_q[0].idx));
`endif
        if (out_ready) begin
          seen_q.push_back(exp_q[0].idx);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_none"}, 32'(out_none), 32'd0);
`ifdef PRIENC_ONEHOT_EN
    chk({tag, "_onehot"}, 32'(out_onehot), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_lg = 0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] r, input logic m);
    in_valid = 1'b1;
    req      = r;
    rr_mode  = m;
    cyc();
  endtask

  initial begin
    int n;
    int exp_seq[5] = '{15, 10, 5, 0, 15};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    req       = '0;
    rr_mode   = 1'b0;
    out_ready = 1'b1;
    model_lg  = 0;
    cyc();
    cyc();
    check_cleared("reset");
    rst_n = 1'b1;
    cyc();

    // Fixed mode basics
    send(16'h8001, 1'b0);
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_idx", 32'(out_idx), 32'd15);
    chk("t1_none", 32'(out_none), 32'd0);
    send(16'h0000, 1'b0);
    chk("t2_none", 32'(out_none), 32'd1);
    chk("t2_idx", 32'(out_idx), 32'd0);
    send(16'h0004, 1'b0);
    in_valid = 1'b0;
    chk("t2b_idx", 32'(out_idx), 32'd2);
    chk("t2b_none", 32'(out_none), 32'd0);
    cyc();

    // Round-robin rotation from a fresh last_grant
    do_reset();
    seen_q.delete();
    repeat (5) send(16'h8421, 1'b1);
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("t3_count", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) chk("t3_seq", 32'(seen_q[i]), 32'(exp_seq[i]));

    // Backpressure then full-throughput drain
    send(16'h0100, 1'b0);
    out_ready = 1'b0;
    req = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_stall_ready", 32'(in_ready), 32'd0);
      chk("t4_stall_idx", 32'(out_idx), 32'd8);
    end
    out_ready = 1'b1;
    cyc();
    chk("t4_b2b_valid0", 32'(out_valid), 32'd1);
    chk("t4_b2b_idx0", 32'(out_idx), 32'd4);
    send(16'h1000, 1'b0);
    in_valid = 1'b0;
    chk("t4_b2b_valid1", 32'(out_valid), 32'd1);
    chk("t4_b2b_idx1", 32'(out_idx), 32'd12);
    cyc();

    // Mode switching keeps last_grant
    send(16'h0400, 1'b1);
    chk("t5_rr10", 32'(out_idx), 32'd10);
    send(16'h0C00, 1'b0);
    chk("t5_fix11", 32'(out_idx), 32'd11);
    send(16'h0C00, 1'b1);
    in_valid = 1'b0;
    chk("t5_rr10b", 32'(out_idx), 32'd10);
    cyc();

    // Asynchronous reset during a stall
    send(16'h0200, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    #3;
    rst_n = 1'b0;
    #1;
    check_cleared("t6");
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    model_lg = 0;
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rr_mode   = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = 16'(1) << $urandom_range(0, WIDTH - 1);
        default: req = 16'($urandom);
      endcase
      cyc();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
